// File: rtl/dcache_pkg.sv
// Shared field layout, FSM states and tag-entry format for the L1 data cache.
package dcache_pkg;
   localparam int LINES     = 16;
   localparam int LINE_BITS = 256;
   localparam int ADDR_W    = 32;
   localparam int WORD_W    = 32;
   localparam int WSEL_LSB  = 2;
   localparam int WSEL_W    = 3;
   localparam int IDX_LSB   = 5;
   localparam int IDX_W     = $clog2(LINES);
   localparam int TAG_LSB   = IDX_LSB + IDX_W;
   localparam int TAG_W     = ADDR_W - TAG_LSB;
   localparam int ENT_W     = TAG_W + 2;

   typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, DONE} state_e;

   typedef struct packed {
      logic             valid;
      logic             dirty;
      logic [TAG_W-1:0] tag;
   } tag_entry_t;
endpackage

// File: rtl/dcache_sram.sv
// Tag + line storage: combinational read by index, synchronous full-line or single-word write.
// Only the tag entries are reset; line data is meaningless while its entry is invalid.
module dcache_sram
   import dcache_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [IDX_W-1:0]     idx_i,
   output logic [ENT_W-1:0]     rd_ent_o,
   output logic [LINE_BITS-1:0] rd_line_o,
   input  logic                 line_we_i,
   input  logic [LINE_BITS-1:0] line_dat_i,
   input  logic [TAG_W-1:0]     line_tag_i,
   input  logic                 word_we_i,
   input  logic [WSEL_W-1:0]    word_sel_i,
   input  logic [WORD_W-1:0]    word_dat_i
);
   tag_entry_t           ent_q  [LINES];
   logic [LINE_BITS-1:0] line_q [LINES];

   assign rd_ent_o  = ent_q[idx_i];
   assign rd_line_o = line_q[idx_i];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < LINES; i++) ent_q[i] <= '0;
      end else if (line_we_i) begin
         ent_q[idx_i] <= '{valid: 1'b1, dirty: 1'b0, tag: line_tag_i};
      end else if (word_we_i) begin
         ent_q[idx_i].dirty <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (line_we_i) begin
         line_q[idx_i] <= line_dat_i;
      end else if (word_we_i) begin
         line_q[idx_i][word_sel_i*WORD_W +: WORD_W] <= word_dat_i;
      end
   end
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back L1 D-cache controller: 0-cycle hits, combinational stall on miss.
// Miss = optional write-back + refill over a single-outstanding memory port, then one DONE cycle.
module dcache_ctrl
   import dcache_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cpu_req_i,
   input  logic                 cpu_write_i,
   input  logic [ADDR_W-1:0]    cpu_addr_i,
   input  logic [WORD_W-1:0]    cpu_data_i,
   output logic [WORD_W-1:0]    cpu_data_o,
   output logic                 cpu_stall_o,
   output logic                 mem_enable_o,
   output logic                 mem_write_o,
   output logic [ADDR_W-1:0]    mem_addr_o,
   output logic [LINE_BITS-1:0] mem_data_o,
   input  logic [LINE_BITS-1:0] mem_data_i,
   input  logic                 mem_ack_i
);
   state_e               state_q, state_d;
   logic [IDX_W-1:0]     idx;
   logic [TAG_W-1:0]     tag;
   logic [WSEL_W-1:0]    wsel;
   logic [ENT_W-1:0]     ent_raw;
   tag_entry_t           ent;
   logic [LINE_BITS-1:0] line;
   logic                 hit, line_we, word_we;
   logic                 unused_addr_lsb;

   assign idx             = cpu_addr_i[IDX_LSB +: IDX_W];
   assign tag             = cpu_addr_i[TAG_LSB +: TAG_W];
   assign wsel            = cpu_addr_i[WSEL_LSB +: WSEL_W];
   assign unused_addr_lsb = ^cpu_addr_i[WSEL_LSB-1:0];
   assign ent             = tag_entry_t'(ent_raw);

   assign hit         = cpu_req_i & ent.valid & (ent.tag == tag);
   assign cpu_stall_o = cpu_req_i & ~hit;
   assign cpu_data_o  = hit ? line[wsel*WORD_W +: WORD_W] : '0;

   // Stores complete as ordinary hits, including the DONE cycle after a refill.
   assign word_we = hit & cpu_write_i;
   assign line_we = (state_q == REFILL) & mem_ack_i;

   dcache_sram u_sram (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .idx_i      (idx),
      .rd_ent_o   (ent_raw),
      .rd_line_o  (line),
      .line_we_i  (line_we),
      .line_dat_i (mem_data_i),
      .line_tag_i (tag),
      .word_we_i  (word_we),
      .word_sel_i (wsel),
      .word_dat_i (cpu_data_i)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (cpu_stall_o) state_d = (ent.valid & ent.dirty) ? WRITEBACK : REFILL;
         WRITEBACK: if (mem_ack_i)   state_d = REFILL;
         REFILL:    if (mem_ack_i)   state_d = DONE;
         DONE:      state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // The victim shares the request's index, so the tag read for the request is the victim tag.
   always_comb begin
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      case (state_q)
         WRITEBACK: begin
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {ent.tag, idx, 5'b0};
            mem_data_o   = line;
         end
         REFILL: begin
            mem_enable_o = 1'b1;
            mem_addr_o   = {tag, idx, 5'b0};
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed table-driven bench for dcache_ctrl plus a hand-written reset-during-refill sequence.
module tb_dcache_ctrl;
   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         cpu_req_i, cpu_write_i, mem_ack_i;
   logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o, mem_addr_o;
   logic         cpu_stall_o, mem_enable_o, mem_write_o;
   logic [255:0] mem_data_o, mem_data_i;

   int n_pass = 0;
   int n_tot  = 0;

   logic [255:0] lines [4];

   typedef struct {
      logic        rst_n, req, wr;
      logic [31:0] addr, wdat;
      logic        ack;
      int          lsel;
      logic        stall, en, mwr;
      logic [31:0] maddr;
      logic        chk;
      logic [31:0] dat;
      int          wbw;
   } vec_t;

   vec_t tbl[$];

   always #5 clk_i = ~clk_i;

   dcache_ctrl dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .cpu_req_i    (cpu_req_i),
      .cpu_write_i  (cpu_write_i),
      .cpu_addr_i   (cpu_addr_i),
      .cpu_data_i   (cpu_data_i),
      .cpu_data_o   (cpu_data_o),
      .cpu_stall_o  (cpu_stall_o),
      .mem_enable_o (mem_enable_o),
      .mem_write_o  (mem_write_o),
      .mem_addr_o   (mem_addr_o),
      .mem_data_o   (mem_data_o),
      .mem_data_i   (mem_data_i),
      .mem_ack_i    (mem_ack_i)
   );

   function automatic vec_t V(input logic rst_n, input logic req, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wdat,
                              input logic ack, input int lsel,
                              input logic stall, input logic en, input logic mwr,
                              input logic [31:0] maddr, input logic chk,
                              input logic [31:0] dat, input int wbw);
      vec_t v;
      v.rst_n = rst_n; v.req = req; v.wr = wr; v.addr = addr; v.wdat = wdat;
      v.ack = ack; v.lsel = lsel; v.stall = stall; v.en = en; v.mwr = mwr;
      v.maddr = maddr; v.chk = chk; v.dat = dat; v.wbw = wbw;
      return v;
   endfunction

   task automatic check(input string name, input int row, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s row %0d: got 0x%08h expected 0x%08h", name, row, act, exp);
   endtask

   task automatic drive(input logic rst_n, input logic req, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdat,
                        input logic ack, input int lsel);
      rst_i       = rst_n;
      cpu_req_i   = req;
      cpu_write_i = wr;
      cpu_addr_i  = addr;
      cpu_data_i  = wdat;
      mem_ack_i   = ack;
      mem_data_i  = lines[lsel];
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 0);
      lines[0] = {192'h0, 32'h11111111, 32'hDEADBEEF};
      lines[1] = {192'h0, 32'h22222222, 32'hCAFEF00D};
      lines[2] = {192'h0, 32'h33333333, 32'hA5A5A5A5};
      lines[3] = {192'h0, 32'h55555555, 32'h44444444};

      //            rst req wr addr          wdata         ack lsel stall en mwr maddr        chk dat           wbw
      tbl.push_back(V(0, 0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 0, 32'h0,   1, 32'h0,        0));
      tbl.push_back(V(1, 0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 0, 32'h0,   1, 32'h0,        0));
      tbl.push_back(V(1, 1, 0, 32'h40,  32'h0,        0, 0, 1, 0, 0, 32'h0,   1, 32'h0,        0));
      tbl.push_back(V(1, 1, 0, 32'h40,  32'h0,        0, 0, 1, 1, 0, 32'h40,  1, 32'h0,        0));
      tbl.push_back(V(1, 1, 0, 32'h40,  32'h0,        1, 0, 1, 1, 0, 32'h40,  1, 32'h0,        0));
      tbl.push_back(V(1, 1, 0, 32'h40,  32'h0,        0, 0, 0, 0, 0, 32'h0,   1, 32'hDEADBEEF, 0));
      tbl.push_back(V(1, 0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 0, 32'h0,   1, 32'h0,        0));
      tbl.push_back(V(1, 1, 1, 32'h44,  32'h12345678, 0, 0, 0, 0, 0, 32'h0,   0, 32'h0,        0));
      tbl.push_back(V(1, 1, 0, 32'h44,  32'h0,        0, 0, 0, 0, 0, 32'h0,   1, 32'h12345678, 0));
      tbl.push_back(V(1, 1, 0, 32'h240, 32'h0,        0, 0, 1, 0, 0, 32'h0,   1, 32'h0,        0));
      tbl.push_back(V(1, 1, 0, 32'h240, 32'h0,        0, 0, 1, 1, 1, 32'h40,  0, 32'h12345678, 1));
      tbl.push_back(V(1, 1, 0, 32'h240, 32'h0,        1, 0, 1, 1, 1, 32'h40,  0, 32'hDEADBEEF, 0));
      tbl.push_back(V(1, 1, 0, 32'h240, 32'h0,        0, 1, 1, 1, 0, 32'h240, 1, 32'h0,        0));
      tbl.push_back(V(1, 1, 0, 32'h240, 32'h0,        1, 1, 1, 1, 0, 32'h240, 1, 32'h0,        0));
      tbl.push_back(V(1, 1, 0, 32'h240, 32'h0,        0, 0, 0, 0, 0, 32'h0,   1, 32'hCAFEF00D, 0));
      tbl.push_back(V(1, 0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 0, 32'h0,   1, 32'h0,        0));
      tbl.push_back(V(1, 1, 0, 32'h440, 32'h0,        0, 0, 1, 0, 0, 32'h0,   1, 32'h0,        0));
      tbl.push_back(V(1, 1, 0, 32'h440, 32'h0,        1, 3, 1, 1, 0, 32'h440, 1, 32'h0,        0));
      tbl.push_back(V(1, 1, 0, 32'h440, 32'h0,        0, 0, 0, 0, 0, 32'h0,   1, 32'h44444444, 0));
      tbl.push_back(V(1, 1, 1, 32'h80,  32'h0BADC0DE, 0, 0, 1, 0, 0, 32'h0,   0, 32'h0,        0));
      tbl.push_back(V(1, 1, 1, 32'h80,  32'h0BADC0DE, 1, 2, 1, 1, 0, 32'h80,  0, 32'h0,        0));
      tbl.push_back(V(1, 1, 1, 32'h80,  32'h0BADC0DE, 0, 0, 0, 0, 0, 32'h0,   0, 32'h0,        0));
      tbl.push_back(V(1, 1, 0, 32'h80,  32'h0,        0, 0, 0, 0, 0, 32'h0,   1, 32'h0BADC0DE, 0));
      tbl.push_back(V(1, 1, 0, 32'h84,  32'h0,        0, 0, 0, 0, 0, 32'h0,   1, 32'h33333333, 0));
      tbl.push_back(V(1, 1, 0, 32'h280, 32'h0,        0, 0, 1, 0, 0, 32'h0,   1, 32'h0,        0));
      tbl.push_back(V(1, 1, 0, 32'h280, 32'h0,        1, 0, 1, 1, 1, 32'h80,  0, 32'h0BADC0DE, 0));
      tbl.push_back(V(1, 1, 0, 32'h280, 32'h0,        1, 1, 1, 1, 0, 32'h280, 1, 32'h0,        0));
      tbl.push_back(V(1, 1, 0, 32'h280, 32'h0,        0, 0, 0, 0, 0, 32'h0,   1, 32'hCAFEF00D, 0));
      tbl.push_back(V(1, 0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 0, 32'h0,   1, 32'h0,        0));

      foreach (tbl[r]) begin
         @(posedge clk_i);
         #1;
         drive(tbl[r].rst_n, tbl[r].req, tbl[r].wr, tbl[r].addr, tbl[r].wdat,
               tbl[r].ack, tbl[r].lsel);
         #2;
         check("stall", r, {31'b0, cpu_stall_o}, {31'b0, tbl[r].stall});
         check("mem_enable", r, {31'b0, mem_enable_o}, {31'b0, tbl[r].en});
         check("mem_write", r, {31'b0, mem_write_o}, {31'b0, tbl[r].mwr});
         check("mem_addr", r, mem_addr_o, tbl[r].maddr);
         if (tbl[r].chk) check("cpu_data", r, cpu_data_o, tbl[r].dat);
         if (tbl[r].mwr) check("wb_word", r, mem_data_o[tbl[r].wbw*32 +: 32], tbl[r].dat);
         else            check("mem_data_zero", r, {31'b0, |mem_data_o}, 32'h0);
      end

      // Reset lands mid-refill; the late ack must not fill the line.
      @(posedge clk_i); #1;
      drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 0);
      #2;
      check("rst_seq_miss_stall", 100, {31'b0, cpu_stall_o}, 32'h1);
      @(posedge clk_i); #3;
      check("rst_seq_refill_en", 101, {31'b0, mem_enable_o}, 32'h1);
      check("rst_seq_refill_addr", 101, mem_addr_o, 32'h40);
      #1;
      drive(1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 0);
      #1;
      check("rst_seq_async_en", 102, {31'b0, mem_enable_o}, 32'h0);
      check("rst_seq_async_addr", 102, mem_addr_o, 32'h0);
      check("rst_seq_async_stall", 102, {31'b0, cpu_stall_o}, 32'h0);
      @(posedge clk_i); #1;
      drive(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 0);
      #2;
      check("rst_seq_stray_ack_en", 103, {31'b0, mem_enable_o}, 32'h0);
      check("rst_seq_stray_ack_stall", 103, {31'b0, cpu_stall_o}, 32'h0);
      @(posedge clk_i); #1;
      drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 0);
      #2;
      check("rst_seq_remiss_stall", 104, {31'b0, cpu_stall_o}, 32'h1);
      check("rst_seq_remiss_en", 104, {31'b0, mem_enable_o}, 32'h0);
      @(posedge clk_i); #3;
      check("rst_seq_refill2_en", 105, {31'b0, mem_enable_o}, 32'h1);
      check("rst_seq_refill2_wr", 105, {31'b0, mem_write_o}, 32'h0);
      check("rst_seq_refill2_addr", 105, mem_addr_o, 32'h40);
      mem_ack_i = 1'b1;
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0;
      #2;
      check("rst_seq_done_stall", 106, {31'b0, cpu_stall_o}, 32'h0);
      check("rst_seq_done_data", 106, cpu_data_o, 32'hDEADBEEF);
      @(posedge clk_i); #1;
      cpu_req_i = 1'b0;
      #2;
      check("rst_seq_idle_en", 107, {31'b0, mem_enable_o}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
